// File: rtl/selftrigger_threshold_ctrl_pkg.sv
// Shared constants, op codes and FSM state encoding for the threshold
// command sequencer and its verify pipeline.
package selftrigger_pkg;

  localparam int NUM_CH   = 40;
  localparam int CH_W     = 8;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;
  localparam int CNT_W    = 8;

  // Value the threshold bank holds after its own reset
  localparam logic [DATA_W-1:0] THR_RESET_VALUE = 32'd99999;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_BCAST  = 2'b10,
    OP_VERIFY = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_WAIT,
    ST_BCAST,
    ST_VERIFY,
    ST_RESP
  } state_e;

  // True when the channel index addresses a real threshold register
  function automatic logic ch_legal(input logic [CH_W-1:0] ch);
    return int'(ch) < NUM_CH;
  endfunction

endpackage

// File: rtl/selftrigger_threshold_ctrl_if.sv
// Host-side command/response handshake of the threshold sequencer.
// master = slow-control decoder, slave = sequencer.
interface selftrigger_threshold_ctrl_if;
  import selftrigger_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/selftrigger_threshold_ctrl_thr_verify_pipe.sv
// Verify pipeline: delays the issued channel tag by the bank read latency so
// it lines up with thr_rdata, compares against the expected value, and keeps a
// saturating mismatch count plus the lowest mismatching channel. The *_next
// outputs include the compare of the current cycle so the final channel can be
// folded into the response on the same edge.
module thr_verify_pipe
  import selftrigger_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              issue_valid,
  input  logic [CH_W-1:0]   issue_ch,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] expected,
  output logic [7:0]        count_next,
  output logic [CH_W-1:0]   first_bad_next
);

  localparam logic [CH_W-1:0] NO_BAD = '1;

  logic            vld_reg [READ_LAT];
  logic [CH_W-1:0] ch_reg  [READ_LAT];
  logic [7:0]      count_reg;
  logic [CH_W-1:0] first_bad_reg;
  logic            mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        // First stage captures the channel being presented to the bank
        always_ff @(posedge clk) begin
          if (reset || clear) begin
            vld_reg[gi] <= 1'b0;
            ch_reg[gi]  <= '0;
          end else begin
            vld_reg[gi] <= issue_valid;
            ch_reg[gi]  <= issue_ch;
          end
        end
      end else begin : g_tail
        // Later stages shift the tag toward the compare point
        always_ff @(posedge clk) begin
          if (reset || clear) begin
            vld_reg[gi] <= 1'b0;
            ch_reg[gi]  <= '0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1];
            ch_reg[gi]  <= ch_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign mismatch       = vld_reg[READ_LAT-1] && (rdata != expected);
  assign count_next     = (mismatch && (count_reg != 8'hFF)) ? count_reg + 8'd1 : count_reg;
  assign first_bad_next = (mismatch && (first_bad_reg == NO_BAD)) ? ch_reg[READ_LAT-1] : first_bad_reg;

  // Accumulate mismatch statistics for the verify pass in progress
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg     <= '0;
      first_bad_reg <= NO_BAD;
    end else begin
      count_reg     <= count_next;
      first_bad_reg <= first_bad_next;
    end
  end

endmodule

// File: rtl/selftrigger_threshold_ctrl.sv
// Command sequencer for the threshold register bank: serialises single
// write/read, broadcast write and streamed verify, one command at a time,
// and holds each response until the host consumes it.
module selftrigger_threshold_ctrl
  import selftrigger_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  selftrigger_threshold_ctrl_if.slave   bus,
  output logic                          busy,
  output logic                          thr_write,
  output logic [CH_W-1:0]               thr_ch,
  output logic [DATA_W-1:0]             thr_value,
  input  logic [DATA_W-1:0]             thr_rdata
);

  localparam logic [CNT_W-1:0] RD_DONE       = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] VER_ISSUE_END = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0] VER_LAST_STEP = CNT_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] VER_DONE      = CNT_W'(NUM_CH + READ_LAT - 1);
  localparam logic [CH_W-1:0]  LAST_CH       = CH_W'(NUM_CH - 1);

  state_e            state_reg;
  logic              cmd_ready_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              busy_reg;
  logic              thr_write_reg;
  logic [CH_W-1:0]   thr_ch_reg;
  logic [DATA_W-1:0] thr_value_reg;
  logic [DATA_W-1:0] expect_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              accept;
  logic              cmd_illegal;
  logic              verify_clear;
  logic              issue_valid;
  logic [7:0]        vcount_next;
  logic [CH_W-1:0]   vfirst_next;

  // cmd_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign accept       = bus.cmd_valid && cmd_ready_reg;
  assign cmd_illegal  = ((bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_READ)) && !ch_legal(bus.cmd_ch);
  assign verify_clear = accept && (bus.cmd_op == OP_VERIFY);
  assign issue_valid  = (state_reg == ST_VERIFY) && (cnt_reg < VER_ISSUE_END);

  thr_verify_pipe u_verify (
    .clk            (clk),
    .reset          (reset),
    .clear          (verify_clear),
    .issue_valid    (issue_valid),
    .issue_ch       (thr_ch_reg),
    .rdata          (thr_rdata),
    .expected       (expect_reg),
    .count_next     (vcount_next),
    .first_bad_next (vfirst_next)
  );

  // Sequencer FSM with all host and bank outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      busy_reg      <= 1'b0;
      thr_write_reg <= 1'b0;
      thr_ch_reg    <= '0;
      thr_value_reg <= '0;
      expect_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (accept) begin
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            cnt_reg       <= '0;
            if (cmd_illegal) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_data_reg  <= '0;
            end else begin
              case (bus.cmd_op)
                OP_WRITE: begin
                  state_reg     <= ST_WR;
                  thr_write_reg <= 1'b1;
                  thr_ch_reg    <= bus.cmd_ch;
                  thr_value_reg <= bus.cmd_data;
                end
                OP_READ: begin
                  state_reg  <= ST_RD_WAIT;
                  thr_ch_reg <= bus.cmd_ch;
                end
                OP_BCAST: begin
                  state_reg     <= ST_BCAST;
                  thr_write_reg <= 1'b1;
                  thr_ch_reg    <= '0;
                  thr_value_reg <= bus.cmd_data;
                end
                default: begin
                  state_reg  <= ST_VERIFY;
                  thr_ch_reg <= '0;
                  expect_reg <= bus.cmd_data;
                end
              endcase
            end
          end
        end
        ST_WR: begin
          thr_write_reg <= 1'b0;
          state_reg     <= ST_RESP;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_data_reg  <= '0;
        end
        ST_RD_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == RD_DONE) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= thr_rdata;
          end
        end
        ST_BCAST: begin
          if (thr_ch_reg == LAST_CH) begin
            thr_write_reg <= 1'b0;
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= '0;
          end else begin
            thr_ch_reg <= thr_ch_reg + 1'b1;
          end
        end
        ST_VERIFY: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Channel walks 0..NUM_CH-1 then parks while the pipeline drains
          if (cnt_reg < VER_LAST_STEP) begin
            thr_ch_reg <= thr_ch_reg + 1'b1;
          end
          if (cnt_reg == VER_DONE) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= (vcount_next != 8'd0);
            rsp_data_reg  <= {vfirst_next, {(DATA_W - CH_W - 8){1'b0}}, vcount_next};
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign busy          = busy_reg;
  assign thr_write     = thr_write_reg;
  assign thr_ch        = thr_ch_reg;
  assign thr_value     = thr_value_reg;

endmodule

// File: tb/tb_selftrigger_threshold_ctrl.sv
// Bench for the threshold sequencer: a behavioural bank with two-cycle read
// latency, a transaction-level model of expected responses/strobes checked
// every cycle, and directed commands with hand-computed literal results.
module tb_selftrigger_threshold_ctrl;
  import selftrigger_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              busy;
  logic              thr_write;
  logic [CH_W-1:0]   thr_ch;
  logic [DATA_W-1:0] thr_value;
  logic [DATA_W-1:0] thr_rdata;

  selftrigger_threshold_ctrl_if bus();

  selftrigger_threshold_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .thr_write (thr_write),
    .thr_ch    (thr_ch),
    .thr_value (thr_value),
    .thr_rdata (thr_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Threshold bank stand-in: write port plus two-stage registered read
  logic [31:0] bank_mem [NUM_CH];
  logic [31:0] rd_p1;
  bit bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < NUM_CH; i++) bank_mem[i] <= THR_RESET_VALUE;
      bank_init <= 1'b1;
    end else if (thr_write && (int'(thr_ch) < NUM_CH)) begin
      bank_mem[thr_ch] <= thr_value;
    end
    rd_p1     <= (int'(thr_ch) < NUM_CH) ? bank_mem[thr_ch] : 32'h0;
    thr_rdata <= rd_p1;
  end

  always @(negedge clk) if (thr_write) n_strobes++;

  // Transaction-level model: expected contents, latency, strobes, response
  logic [31:0] sh [NUM_CH];
  bit          model_init = 1'b0;
  bit          outst = 1'b0;
  bit          exp_ready = 1'b0;
  int          k, lat_e, sf, sl, sch0;
  logic [31:0] sval, rdata_e;
  logic        err_e;

  always @(negedge clk) begin : model
    bit ws;
    int ch, mc, fb;
    logic [31:0] dv;
    if (!model_init) begin
      for (int i = 0; i < NUM_CH; i++) sh[i] = THR_RESET_VALUE;
      model_init = 1'b1;
    end
    ws = outst && (k >= sf) && (k <= sl);
    chk("cmd_ready", bus.cmd_ready, exp_ready);
    chk("busy", busy, outst);
    chk("rsp_valid", bus.rsp_valid, outst && (k >= lat_e));
    chk("thr_write", thr_write, ws);
    if (ws) begin
      chk("thr_ch", thr_ch, sch0 + k - sf);
      chk("thr_value", thr_value, sval);
      sh[sch0 + k - sf] = sval;
    end
    if (outst && (k >= lat_e)) begin
      chk("rsp_data", bus.rsp_data, rdata_e);
      chk("rsp_err", bus.rsp_err, err_e);
    end
    // Advance model to the state after the coming edge
    if (reset) begin
      outst = 1'b0;
      exp_ready = 1'b0;
    end else if (outst) begin
      if ((k >= lat_e) && bus.rsp_ready) begin
        outst = 1'b0;
        exp_ready = 1'b1;
      end else begin
        k++;
      end
    end else if (bus.cmd_valid && exp_ready) begin
      ch = int'(bus.cmd_ch);
      dv = bus.cmd_data;
      sf = 1; sl = 0; sch0 = 0; sval = 0; rdata_e = 0; err_e = 1'b0;
      if (((bus.cmd_op == OP_WRITE) || (bus.cmd_op == OP_READ)) && (ch >= NUM_CH)) begin
        lat_e = 1;
        err_e = 1'b1;
      end else begin
        case (bus.cmd_op)
          OP_WRITE:  begin lat_e = 2; sl = 1; sch0 = ch; sval = dv; end
          OP_READ:   begin lat_e = READ_LAT + 2; rdata_e = sh[ch]; end
          OP_BCAST:  begin lat_e = NUM_CH + 1; sl = NUM_CH; sval = dv; end
          default: begin
            lat_e = NUM_CH + READ_LAT + 1;
            mc = 0; fb = 255;
            for (int i = 0; i < NUM_CH; i++) begin
              if (sh[i] != dv) begin
                if (fb == 255) fb = i;
                if (mc < 255) mc++;
              end
            end
            rdata_e = (32'(fb) << 24) | 32'(mc);
            err_e = (mc != 0);
          end
        endcase
      end
      outst = 1'b1;
      exp_ready = 1'b0;
      k = 1;
    end else begin
      exp_ready = 1'b1;
    end
  end

  // Issue one command, measure accept->rsp_valid latency, capture response
  task automatic do_cmd(input op_e op, input int ch, input logic [31:0] data,
                        input int hold, input bit early,
                        output logic [31:0] d, output logic e, output int lat);
    int g;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ch    = ch[7:0];
    bus.cmd_data  = data;
    bus.rsp_ready = early;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.cmd_ready && g < 100);
    if (g >= 100) chk("accept_timeout", 32'(g), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 200);
    if (lat >= 200) chk("rsp_timeout", 32'(lat), 32'd0);
    d = bus.rsp_data;
    e = bus.rsp_err;
    @(posedge clk);
    if (early) begin
      #1 bus.rsp_ready = 1'b0;
    end else begin
      repeat (hold) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    logic        e;
    int          lat, g;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_ch    = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_thr_ch", thr_ch, 32'd0);
    chk("reset_thr_value", thr_value, 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    chk("reset_rsp_err", bus.rsp_err, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    do_cmd(OP_READ, 5, 32'd0, 0, 1'b0, d, e, lat);
    $display("READ ch5 data=%0d err=%0b lat=%0d", d, e, lat);
    chk("read5_data", d, 32'd99999);
    chk("read5_err", e, 32'd0);
    chk("read5_lat", 32'(lat), 32'd4);

    n_strobes = 0;
    do_cmd(OP_WRITE, 12, -32'sd250, 0, 1'b0, d, e, lat);
    $display("WRITE ch12 err=%0b lat=%0d strobes=%0d", e, lat, n_strobes);
    chk("write12_lat", 32'(lat), 32'd2);
    chk("write12_strobes", 32'(n_strobes), 32'd1);
    do_cmd(OP_READ, 12, 32'd0, 0, 1'b0, d, e, lat);
    $display("READ ch12 data=%h err=%0b", d, e);
    chk("read12_data", d, 32'hFFFF_FF06);

    n_strobes = 0;
    do_cmd(OP_WRITE, 40, 32'd1, 0, 1'b1, d, e, lat);
    $display("WRITE ch40 data=%h err=%0b lat=%0d", d, e, lat);
    chk("write40_err", e, 32'd1);
    chk("write40_lat", 32'(lat), 32'd1);
    do_cmd(OP_READ, 200, 32'd0, 1, 1'b0, d, e, lat);
    $display("READ ch200 data=%h err=%0b lat=%0d", d, e, lat);
    chk("read200_err", e, 32'd1);
    chk("read200_data", d, 32'd0);
    chk("read200_lat", 32'(lat), 32'd1);
    chk("illegal_strobes", 32'(n_strobes), 32'd0);

    n_strobes = 0;
    do_cmd(OP_BCAST, 0, 32'd1200, 0, 1'b0, d, e, lat);
    $display("BCAST 1200 lat=%0d strobes=%0d", lat, n_strobes);
    chk("bcast_lat", 32'(lat), 32'd41);
    chk("bcast_strobes", 32'(n_strobes), 32'd40);
    do_cmd(OP_VERIFY, 0, 32'd1200, 0, 1'b0, d, e, lat);
    $display("VERIFY 1200 data=%h err=%0b lat=%0d", d, e, lat);
    chk("verify_ok_data", d, 32'hFF00_0000);
    chk("verify_ok_err", e, 32'd0);
    chk("verify_lat", 32'(lat), 32'd43);

    do_cmd(OP_WRITE, 7, 32'd5, 0, 1'b0, d, e, lat);
    $display("WRITE ch7 err=%0b", e);
    do_cmd(OP_VERIFY, 0, 32'd1200, 5, 1'b0, d, e, lat);
    $display("VERIFY 1200 data=%h err=%0b", d, e);
    chk("verify_bad7_data", d, 32'h0700_0001);
    chk("verify_bad7_err", e, 32'd1);

    // Broadcast aborted by reset once channel 20 has been strobed
    n_strobes = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_BCAST;
    bus.cmd_data  = 32'd777;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.cmd_ready && g < 100);
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!(thr_write && thr_ch == 8'd20) && g < 100);
    if (g >= 100) chk("abort_wait_timeout", 32'(g), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    $display("ABORT BCAST busy=%0b rsp_valid=%0b strobes=%0d", busy, bus.rsp_valid, n_strobes);
    chk("abort_busy", busy, 32'd0);
    chk("abort_rsp_valid", bus.rsp_valid, 32'd0);
    chk("abort_strobes", 32'(n_strobes), 32'd22);

    do_cmd(OP_READ, 7, 32'd0, 0, 1'b0, d, e, lat);
    $display("READ ch7 data=%0d", d);
    chk("read7_after_abort", d, 32'd777);
    do_cmd(OP_READ, 30, 32'd0, 0, 1'b0, d, e, lat);
    $display("READ ch30 data=%0d", d);
    chk("read30_after_abort", d, 32'd1200);
    do_cmd(OP_VERIFY, 0, 32'd1200, 0, 1'b0, d, e, lat);
    $display("VERIFY 1200 data=%h err=%0b", d, e);
    chk("verify_abort_data", d, 32'h0000_0016);
    chk("verify_abort_err", e, 32'd1);

    do_cmd(OP_BCAST, 0, 32'd0, 0, 1'b0, d, e, lat);
    $display("BCAST 0 lat=%0d", lat);
    do_cmd(OP_WRITE, 39, 32'hFFFF_FFFF, 0, 1'b0, d, e, lat);
    $display("WRITE ch39 err=%0b", e);
    do_cmd(OP_VERIFY, 0, 32'd0, 0, 1'b0, d, e, lat);
    $display("VERIFY 0 data=%h err=%0b", d, e);
    chk("verify_bad39_data", d, 32'h2700_0001);
    chk("verify_bad39_err", e, 32'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
